dcache_responder: RTL and testbench



---
 rtl/dcache_responder_if.sv | 24 ++
 rtl/dcache_responder.sv | 170 +++++++++++++++++
 tb/tb_dcache_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_responder_if.sv
// Mem-stage data-access bundle between the pipeline and the data responder.
interface dcache_responder_if;
  logic        Mem_DcacheEN;
  logic        Mem_DcacheRd;
  logic [1:0]  Mem_DcacheWidth;
  logic [31:0] Mem_DcacheAddr;
  logic        Mem_DcacheSign;
  logic [31:0] EXMem_Rs2Data;
  logic [31:0] Dcache_DataRd;
  logic        Dcache_StallReq;
  logic        Dcache_MisalignExcp;

  modport master (
    output Mem_DcacheEN, Mem_DcacheRd, Mem_DcacheWidth, Mem_DcacheAddr,
           Mem_DcacheSign, EXMem_Rs2Data,
    input  Dcache_DataRd, Dcache_StallReq, Dcache_MisalignExcp
  );

  modport slave (
    input  Mem_DcacheEN, Mem_DcacheRd, Mem_DcacheWidth, Mem_DcacheAddr,
           Mem_DcacheSign, EXMem_Rs2Data,
    output Dcache_DataRd, Dcache_StallReq, Dcache_MisalignExcp
  );
endinterface

// File: rtl/dcache_responder.sv
// Word-organised data responder; word-crossing accesses split into two beats.
// DCACHE_MISALIGN_TRAP_EN: crossing accesses raise Dcache_MisalignExcp instead.
//   state  | meaning
//   IDLE   | accept request; aligned access completes this cycle
//   SECOND | finish second beat of a crossing access from holding registers
module dcache_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  dcache_responder_if.slave bus
);

  typedef enum logic {IDLE, SECOND} stateT;

  stateT state, nextState;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [4:0]    offSh;
  logic [3:0]    widthMask;
  logic [3:0]    beLow;
  logic          crossing;
  logic [31:0]   rdWordA;
  logic [31:0]   rdWordB;
  logic          unusedAddrBits;

  logic          rdQ;
  logic [1:0]    widthQ;
  logic          signQ;
  logic [AW-1:0] idxNextQ;
  logic [1:0]    offQ;
  logic [31:0]   dataQ;
  logic [31:0]   lowPartQ;
  logic [2:0]    remQ;
  logic [5:0]    hiShQ;
  logic [3:0]    widthMaskQ;

  logic          capture;
  logic          wEn;
  logic [AW-1:0] wIdx;
  logic [31:0]   wData;
  logic [3:0]    wBe;
  logic [31:0]   dataRd;
  logic          stallReq;
  logic          misalignExcp;

  function automatic logic [3:0] maskOf(input logic [1:0] w);
    case (w)
      2'b00:   maskOf = 4'b0001;
      2'b01:   maskOf = 4'b0011;
      default: maskOf = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extendLoad(input logic [31:0] d, input logic [1:0] w,
                                             input logic s);
    case (w)
      2'b00:   extendLoad = {{24{s & d[7]}}, d[7:0]};
      2'b01:   extendLoad = {{16{s & d[15]}}, d[15:0]};
      default: extendLoad = d;
    endcase
  endfunction

  assign idx            = bus.Mem_DcacheAddr[AW+1:2];
  assign off            = bus.Mem_DcacheAddr[1:0];
  assign unusedAddrBits = ^bus.Mem_DcacheAddr[31:AW+2];
  assign offSh          = {off, 3'b000};
  assign widthMask      = maskOf(bus.Mem_DcacheWidth);
  assign beLow          = widthMask << off;
  assign crossing       = ((bus.Mem_DcacheWidth == 2'b01) && (off == 2'd3)) ||
                          (bus.Mem_DcacheWidth[1] && (off != 2'd0));

  assign rdWordA = mem[idx];
  assign rdWordB = mem[idxNextQ];

  // Bytes already taken from the first word decide how far the second word shifts.
  assign remQ       = 3'd4 - {1'b0, offQ};
  assign hiShQ      = {remQ, 3'b000};
  assign widthMaskQ = maskOf(widthQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState    = state;
    dataRd       = '0;
    stallReq     = 1'b0;
    misalignExcp = 1'b0;
    capture      = 1'b0;
    wEn          = 1'b0;
    wIdx         = idx;
    wData        = bus.EXMem_Rs2Data << offSh;
    wBe          = '0;
    case (state)
      IDLE: begin
        if (bus.Mem_DcacheEN) begin
          if (!crossing) begin
            if (bus.Mem_DcacheRd) begin
              dataRd = extendLoad(rdWordA >> offSh, bus.Mem_DcacheWidth, bus.Mem_DcacheSign);
            end else begin
              wEn = 1'b1;
              wBe = beLow;
            end
          end else begin
`ifdef DCACHE_MISALIGN_TRAP_EN
            misalignExcp = 1'b1;
`else
            stallReq  = 1'b1;
            capture   = 1'b1;
            nextState = SECOND;
            if (!bus.Mem_DcacheRd) begin
              wEn = 1'b1;
              wBe = beLow;
            end
`endif
          end
        end
      end
      SECOND: begin
        nextState = IDLE;
        if (rdQ) begin
          dataRd = extendLoad(lowPartQ | (rdWordB << hiShQ), widthQ, signQ);
        end else begin
          wEn   = 1'b1;
          wIdx  = idxNextQ;
          wData = dataQ >> hiShQ;
          wBe   = widthMaskQ >> remQ;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdQ      <= 1'b0;
      widthQ   <= '0;
      signQ    <= 1'b0;
      idxNextQ <= '0;
      offQ     <= '0;
      dataQ    <= '0;
      lowPartQ <= '0;
    end else if (capture) begin
      rdQ      <= bus.Mem_DcacheRd;
      widthQ   <= bus.Mem_DcacheWidth;
      signQ    <= bus.Mem_DcacheSign;
      idxNextQ <= idx + AW'(1);
      offQ     <= off;
      dataQ    <= bus.EXMem_Rs2Data;
      lowPartQ <= rdWordA >> offSh;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wEn && wBe[b]) mem[wIdx][b*8 +: 8] <= wData[b*8 +: 8];
    end
  end

  assign bus.Dcache_DataRd       = dataRd;
  assign bus.Dcache_StallReq     = stallReq;
  assign bus.Dcache_MisalignExcp = misalignExcp;

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: per-cycle expectations queued by stimulus, checked at negedge.
module tb_dcache_responder;

  localparam int DEPTH = 1024;
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dcache_responder_if bus();

  dcache_responder #(.DEPTH(DEPTH), .AW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        stall;
    logic        excp;
  } expT;

  expT sbQ[$];
  expT monExp;
  int  checks = 0;
  int  failures = 0;

  task automatic cyc(input logic r, input logic en, input logic rd, input logic [1:0] w,
                     input logic [31:0] a, input logic s, input logic [31:0] d,
                     input logic [31:0] eD, input logic eS, input logic eX, input string nm);
    @(posedge clk);
    #1;
    rst_n               = r;
    bus.Mem_DcacheEN    = en;
    bus.Mem_DcacheRd    = rd;
    bus.Mem_DcacheWidth = w;
    bus.Mem_DcacheAddr  = a;
    bus.Mem_DcacheSign  = s;
    bus.EXMem_Rs2Data   = d;
    sbQ.push_back('{name: nm, data: eD, stall: eS, excp: eX});
  endtask

  task automatic st(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                    input string nm);
    cyc(1'b1, 1'b1, 1'b0, w, a, 1'b0, d, 32'h0, 1'b0, 1'b0, nm);
  endtask

  task automatic ld(input logic [1:0] w, input logic [31:0] a, input logic s,
                    input logic [31:0] e, input string nm);
    cyc(1'b1, 1'b1, 1'b1, w, a, s, 32'h0, e, 1'b0, 1'b0, nm);
  endtask

  // Request cycle of a crossing access; the returned data must be 0 while stalled.
  task automatic first(input logic rd, input logic [1:0] w, input logic [31:0] a,
                       input logic s, input logic [31:0] d, input string nm);
    cyc(1'b1, 1'b1, rd, w, a, s, d, 32'h0, 1'b1, 1'b0, nm);
  endtask

  // Second-beat cycle driven with unrelated request values that must be ignored.
  task automatic second(input logic [31:0] e, input string nm);
    cyc(1'b1, 1'b1, 1'b0, W_WORD, 32'h30, 1'b1, 32'hFFFF_FFFF, e, 1'b0, 1'b0, nm);
  endtask

  task automatic idle(input string nm);
    cyc(1'b1, 1'b0, 1'b0, W_BYTE, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, nm);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        monExp = sbQ.pop_front();
        checks++;
        if (bus.Dcache_DataRd !== monExp.data || bus.Dcache_StallReq !== monExp.stall ||
            bus.Dcache_MisalignExcp !== monExp.excp) begin
          failures++;
          $display("FAIL %s: got data=%h stall=%b excp=%b, want data=%h stall=%b excp=%b",
                   monExp.name, bus.Dcache_DataRd, bus.Dcache_StallReq,
                   bus.Dcache_MisalignExcp, monExp.data, monExp.stall, monExp.excp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.Mem_DcacheEN    = 1'b0;
    bus.Mem_DcacheRd    = 1'b0;
    bus.Mem_DcacheWidth = W_BYTE;
    bus.Mem_DcacheAddr  = 32'h0;
    bus.Mem_DcacheSign  = 1'b0;
    bus.EXMem_Rs2Data   = 32'h0;

    cyc(1'b0, 1'b0, 1'b0, W_BYTE, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "reset_outputs");
    cyc(1'b0, 1'b0, 1'b0, W_BYTE, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "reset_hold");

    st(W_WORD, 32'h10, 32'hDEAD_BEEF, "store_word_10");
    ld(W_WORD, 32'h10, 1'b0, 32'hDEAD_BEEF, "load_word_10");
    ld(W_BYTE, 32'h13, 1'b1, 32'hFFFF_FFDE, "load_byte_13_s");
    ld(W_BYTE, 32'h13, 1'b0, 32'h0000_00DE, "load_byte_13_u");
    ld(W_HALF, 32'h12, 1'b1, 32'hFFFF_DEAD, "load_half_12_s");
    ld(W_HALF, 32'h10, 1'b0, 32'h0000_BEEF, "load_half_10_u");
    ld(W_HALF, 32'h10, 1'b1, 32'hFFFF_BEEF, "load_half_10_s");
    ld(W_BYTE, 32'h11, 1'b0, 32'h0000_00BE, "load_byte_11_u");
    st(W_BYTE, 32'h11, 32'hFFFF_FF5A, "store_byte_11");
    ld(W_WORD, 32'h10, 1'b0, 32'hDEAD_5AEF, "load_after_byte_store");
    st(W_HALF, 32'h12, 32'hAAAA_1234, "store_half_12");
    ld(W_WORD, 32'h10, 1'b0, 32'h1234_5AEF, "load_after_half_store");
    ld(W_WORD, 32'hABC0_0010, 1'b0, 32'h1234_5AEF, "load_high_addr_bits_ignored");

    st(W_WORD, 32'h20, 32'h4433_2211, "store_word_20");
    st(W_WORD, 32'h24, 32'h8877_6655, "store_word_24");
    st(W_WORD, 32'h28, 32'h0000_00F0, "store_word_28");
    st(W_WORD, 32'h30, 32'h0000_0000, "store_word_30");
    idle("idle_gap");

`ifdef DCACHE_MISALIGN_TRAP_EN
    cyc(1'b1, 1'b1, 1'b1, W_WORD, 32'h21, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "trap_load_21");
    idle("trap_pulse_one_cycle");
    cyc(1'b1, 1'b1, 1'b0, W_WORD, 32'h21, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1,
        "trap_store_21");
    cyc(1'b1, 1'b1, 1'b0, W_HALF, 32'h23, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1,
        "trap_store_half_23");
    ld(W_WORD, 32'h20, 1'b0, 32'h4433_2211, "trap_word_20_unchanged");
    ld(W_WORD, 32'h24, 1'b0, 32'h8877_6655, "trap_word_24_unchanged");
    ld(W_HALF, 32'h22, 1'b1, 32'h0000_4433, "trap_aligned_half_ok");
`else
    first(1'b1, W_WORD, 32'h21, 1'b0, 32'h0, "mis_load_21_beat0");
    second(32'h5544_3322, "mis_load_21_beat1");
    ld(W_WORD, 32'h30, 1'b0, 32'h0000_0000, "second_beat_inputs_ignored");
    first(1'b1, W_HALF, 32'h23, 1'b1, 32'h0, "mis_half_23_beat0");
    second(32'h0000_5544, "mis_half_23_beat1");
    ld(W_WORD, 32'h24, 1'b0, 32'h8877_6655, "back_to_back_after_second");
    first(1'b1, W_WORD, 32'h23, 1'b0, 32'h0, "mis_load_23_beat0");
    second(32'h7766_5544, "mis_load_23_beat1");
    first(1'b1, W_HALF, 32'h27, 1'b1, 32'h0, "mis_half_27_beat0");
    second(32'hFFFF_F088, "mis_half_27_s_beat1");

    first(1'b1, W_WORD, 32'h21, 1'b0, 32'h0, "rst_second_beat0");
    cyc(1'b0, 1'b0, 1'b0, W_BYTE, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "rst_in_second");
    ld(W_WORD, 32'h24, 1'b0, 32'h8877_6655, "load_after_rst_in_second");

    st(W_WORD, 32'h20, 32'h0, "zero_word_20");
    st(W_WORD, 32'h24, 32'h0, "zero_word_24");
    first(1'b0, W_HALF, 32'h23, 1'b0, 32'h0000_ABCD, "mis_store_half_beat0");
    idle("mis_store_half_beat1");
    ld(W_WORD, 32'h20, 1'b0, 32'hCD00_0000, "mis_store_half_word20");
    ld(W_WORD, 32'h24, 1'b0, 32'h0000_00AB, "mis_store_half_word24");
    first(1'b0, W_WORD, 32'h22, 1'b0, 32'h1122_3344, "mis_store_word_beat0");
    second(32'h0, "mis_store_word_beat1");
    ld(W_WORD, 32'h20, 1'b0, 32'h3344_0000, "mis_store_word_word20");
    ld(W_WORD, 32'h24, 1'b0, 32'h0000_1122, "mis_store_word_word24");

    st(W_WORD, 4*DEPTH-4, 32'hCAFE_F00D, "store_last_word");
    st(W_WORD, 32'h0, 32'h0102_0304, "store_word_0");
    first(1'b1, W_WORD, 4*DEPTH-2, 1'b0, 32'h0, "wrap_load_beat0");
    idle("wrap_load_beat1");
    sbQ[sbQ.size()-1].data = 32'h0304_CAFE;
`endif
    idle("final_idle");

    guard = 0;
    while (sbQ.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (sbQ.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
